// File: rtl/if_stage_if.sv
// Instruction-memory req/ack bus between the fetch stage (master) and memory (slave).
// The address is held stable by the master until the transfer completes on req && ack.
interface if_stage_if #(
    parameter int ADDR_W = 30,
    parameter int INSN_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [INSN_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, fetches over req/ack and feeds the IF/ID register.
// Latency: ack cycle N -> if_* valid in N+1; one instruction per cycle with zero-wait memory.
// Backpressure: stall during an ack parks the word in a one-entry hold buffer and pauses requests.
module if_stage #(
    parameter int                ADDR_W   = 30,
    parameter int                INSN_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [INSN_W-1:0] NOP_INSN = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    if_stage_if.master        imem,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INSN_W-1:0] if_insn,
    output logic              if_en
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_nx;
    logic [ADDR_W-1:0] redir_pc, redir_pc_nx;
    logic [ADDR_W-1:0] buf_pc, buf_pc_nx;
    logic [INSN_W-1:0] buf_insn, buf_insn_nx;
    logic [ADDR_W-1:0] if_pc_nx;
    logic [INSN_W-1:0] if_insn_nx;
    logic              if_en_nx;
    logic              xfer;

    assign imem.imem_req  = (state == FETCH) || (state == DROP);
    assign imem.imem_addr = fetch_pc;
    assign xfer           = imem.imem_req && imem.imem_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            redir_pc <= '0;
            buf_pc   <= '0;
            buf_insn <= '0;
            if_pc    <= '0;
            if_insn  <= NOP_INSN;
            if_en    <= 1'b0;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            redir_pc <= redir_pc_nx;
            buf_pc   <= buf_pc_nx;
            buf_insn <= buf_insn_nx;
            if_pc    <= if_pc_nx;
            if_insn  <= if_insn_nx;
            if_en    <= if_en_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        redir_pc_nx = redir_pc;
        buf_pc_nx   = buf_pc;
        buf_insn_nx = buf_insn;
        if_pc_nx    = if_pc;
        if_insn_nx  = if_insn;
        if_en_nx    = if_en;

        if (br_taken) begin
            // A redirect kills whatever is presented, stall or not.
            if_en_nx   = 1'b0;
            if_insn_nx = NOP_INSN;
            case (state)
                FETCH: begin
                    if (xfer) begin
                        fetch_pc_nx = br_addr;
                    end else begin
                        redir_pc_nx = br_addr;
                        state_nx    = DROP;
                    end
                end
                DROP: begin
                    redir_pc_nx = br_addr;
                    if (xfer) begin
                        fetch_pc_nx = br_addr;
                        state_nx    = FETCH;
                    end
                end
                default: begin
                    fetch_pc_nx = br_addr;
                    state_nx    = FETCH;
                end
            endcase
        end else begin
            case (state)
                IDLE: state_nx = FETCH;
                FETCH: begin
                    if (xfer) begin
                        fetch_pc_nx = fetch_pc + ADDR_W'(1);
                        if (stall) begin
                            buf_pc_nx   = fetch_pc;
                            buf_insn_nx = imem.imem_rdata;
                            state_nx    = HOLD;
                        end else begin
                            if_pc_nx   = fetch_pc;
                            if_insn_nx = imem.imem_rdata;
                            if_en_nx   = 1'b1;
                        end
                    end else if (!stall) begin
                        if_en_nx   = 1'b0;
                        if_insn_nx = NOP_INSN;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_pc_nx   = buf_pc;
                        if_insn_nx = buf_insn;
                        if_en_nx   = 1'b1;
                        state_nx   = FETCH;
                    end
                end
                DROP: begin
                    // Data of the abandoned fetch never reaches if_insn.
                    if_en_nx = 1'b0;
                    if (xfer) begin
                        fetch_pc_nx = redir_pc;
                        state_nx    = FETCH;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, corner sequences, then random traffic against a queue-based model.
module tb_if_stage;
    localparam int              AW   = 30;
    localparam int              IW   = 32;
    localparam logic [IW-1:0]   NOP  = 32'h0000_0013;
    localparam logic [AW-1:0]   MAXA = {AW{1'b1}};

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          br_taken;
    logic [AW-1:0] br_addr;
    logic [AW-1:0] if_pc;
    logic [IW-1:0] if_insn;
    logic          if_en;

    if_stage_if #(.ADDR_W(AW), .INSN_W(IW)) imem ();

    if_stage #(.ADDR_W(AW), .INSN_W(IW), .RESET_PC('0), .NOP_INSN(NOP)) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .br_taken (br_taken),
        .br_addr  (br_addr),
        .imem     (imem),
        .if_pc    (if_pc),
        .if_insn  (if_insn),
        .if_en    (if_en)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic          stall;
        logic          br;
        logic          ack;
        logic [AW-1:0] baddr;
        logic [IW-1:0] rdata;
        logic          req;
        logic [AW-1:0] addr;
        logic          en;
        logic [AW-1:0] pc;
        logic [IW-1:0] insn;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(logic s, logic b, logic a, logic [AW-1:0] ba, logic [IW-1:0] rd,
                                logic rq, logic [AW-1:0] ad, logic e, logic [AW-1:0] p, logic [IW-1:0] i);
        vec_t v;
        v.stall = s;  v.br = b;    v.ack = a; v.baddr = ba; v.rdata = rd;
        v.req   = rq; v.addr = ad; v.en  = e; v.pc    = p;  v.insn  = i;
        return v;
    endfunction

    function automatic logic [IW-1:0] mem_word(logic [AW-1:0] a);
        return {2'b10, a} ^ 32'h5A5A_0000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic e_req, logic [AW-1:0] e_addr, logic e_en,
                         logic [AW-1:0] e_pc, logic [IW-1:0] e_insn);
        vectors++;
        if ({imem.imem_req, imem.imem_addr, if_en, if_pc, if_insn} !== {e_req, e_addr, e_en, e_pc, e_insn}) begin
            miscompares++;
            $display("FAIL %s: got req=%0b addr=%h en=%0b pc=%h insn=%h, expected req=%0b addr=%h en=%0b pc=%h insn=%h",
                     name, imem.imem_req, imem.imem_addr, if_en, if_pc, if_insn,
                     e_req, e_addr, e_en, e_pc, e_insn);
        end
    endtask

    // Reference model: a fetch stream with a parking queue and a pending-discard flag.
    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] insn;
    } ent_t;

    ent_t          parked[$];
    logic          m_live;
    logic          m_dropping;
    logic [AW-1:0] m_target;
    logic [AW-1:0] m_next;
    logic          m_en;
    logic [AW-1:0] m_pc;
    logic [IW-1:0] m_insn;

    task automatic model_reset();
        parked.delete();
        m_live = 1'b0; m_dropping = 1'b0; m_target = '0; m_next = '0;
        m_en = 1'b0; m_pc = '0; m_insn = NOP;
    endtask

    function automatic logic model_req();
        return m_live && (parked.size() == 0);
    endfunction

    task automatic model_edge(logic rst, logic s, logic b, logic [AW-1:0] ba, logic a, logic [IW-1:0] rd);
        ent_t e;
        if (rst) begin
            model_reset();
        end else if (!m_live) begin
            m_live = 1'b1;
            if (b) begin m_next = ba; m_en = 1'b0; m_insn = NOP; end
        end else if (b) begin
            m_en = 1'b0; m_insn = NOP;
            if (parked.size() != 0) begin
                parked.delete(); m_next = ba;
            end else if (m_dropping) begin
                if (a) begin m_next = ba; m_dropping = 1'b0; end
                else m_target = ba;
            end else if (a) begin
                m_next = ba;
            end else begin
                m_dropping = 1'b1; m_target = ba;
            end
        end else if (parked.size() != 0) begin
            if (!s) begin
                e = parked.pop_front();
                m_pc = e.pc; m_insn = e.insn; m_en = 1'b1;
            end
        end else if (m_dropping) begin
            m_en = 1'b0;
            if (a) begin m_next = m_target; m_dropping = 1'b0; end
        end else if (a) begin
            e.pc = m_next; e.insn = rd;
            if (s) parked.push_back(e);
            else begin m_pc = m_next; m_insn = rd; m_en = 1'b1; end
            m_next = m_next + AW'(1);
        end else if (!s) begin
            m_en = 1'b0; m_insn = NOP;
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_addr = '0;
        imem.imem_ack = 1'b0; imem.imem_rdata = '0;
        step(); step();
        check("reset", 1'b0, '0, 1'b0, '0, NOP);
        reset = 1'b0;

        tbl[0]  = mk(0,0,1,'h0 ,'hBAD , 1,'h0 ,0,'h0 ,NOP);
        tbl[1]  = mk(0,0,1,'h0 ,'h100 , 1,'h1 ,1,'h0 ,'h100);
        tbl[2]  = mk(0,0,1,'h0 ,'h101 , 1,'h2 ,1,'h1 ,'h101);
        tbl[3]  = mk(0,0,0,'h0 ,'h0   , 1,'h2 ,0,'h1 ,NOP);
        tbl[4]  = mk(1,0,1,'h0 ,'h102 , 0,'h3 ,0,'h1 ,NOP);
        tbl[5]  = mk(1,0,1,'h0 ,'hBAD , 0,'h3 ,0,'h1 ,NOP);
        tbl[6]  = mk(0,0,0,'h0 ,'h0   , 1,'h3 ,1,'h2 ,'h102);
        tbl[7]  = mk(0,0,1,'h0 ,'h103 , 1,'h4 ,1,'h3 ,'h103);
        tbl[8]  = mk(1,0,0,'h0 ,'h0   , 1,'h4 ,1,'h3 ,'h103);
        tbl[9]  = mk(0,1,1,'h40,'h104 , 1,'h40,0,'h3 ,NOP);
        tbl[10] = mk(0,0,1,'h0 ,'h140 , 1,'h41,1,'h40,'h140);
        tbl[11] = mk(0,1,0,'h80,'h0   , 1,'h41,0,'h40,NOP);
        tbl[12] = mk(0,1,0,'h90,'h0   , 1,'h41,0,'h40,NOP);
        tbl[13] = mk(0,0,1,'h0 ,'hDEAD, 1,'h90,0,'h40,NOP);
        tbl[14] = mk(0,0,1,'h0 ,'h190 , 1,'h91,1,'h90,'h190);
        tbl[15] = mk(1,0,1,'h0 ,'h191 , 0,'h92,1,'h90,'h190);
        tbl[16] = mk(1,1,0,'h20,'h0   , 1,'h20,0,'h90,NOP);
        tbl[17] = mk(0,0,1,'h0 ,'h120 , 1,'h21,1,'h20,'h120);
        tbl[18] = mk(0,1,0,'h30,'h0   , 1,'h21,0,'h20,NOP);
        tbl[19] = mk(0,1,1,'h35,'hDEAD, 1,'h35,0,'h20,NOP);
        tbl[20] = mk(0,0,1,'h0 ,'h135 , 1,'h36,1,'h35,'h135);

        for (int i = 0; i < 21; i++) begin
            stall = tbl[i].stall; br_taken = tbl[i].br; br_addr = tbl[i].baddr;
            imem.imem_ack = tbl[i].ack; imem.imem_rdata = tbl[i].rdata;
            step();
            check($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].en, tbl[i].pc, tbl[i].insn);
        end
        stall = 1'b0; br_taken = 1'b0; br_addr = '0;

        // Ack on every third request cycle.
        for (int k = 0; k < 9; k++) begin
            logic [AW-1:0] a;
            logic          ak;
            a  = AW'(32'h36 + k / 3);
            ak = (k % 3 == 2);
            imem.imem_ack   = ak;
            imem.imem_rdata = ak ? ({2'b00, a} + 32'h100) : 32'hBAD;
            step();
            check($sformatf("ack3_%0d", k), 1'b1, AW'(32'h36 + (k + 1) / 3), ak,
                  AW'(32'h35 + (k + 1) / 3), ak ? ({2'b00, a} + 32'h100) : NOP);
        end

        // PC wrap at the top of the address space.
        br_taken = 1'b1; br_addr = MAXA; imem.imem_ack = 1'b1; imem.imem_rdata = 32'hBAD;
        step();
        check("wrap_br", 1'b1, MAXA, 1'b0, AW'(32'h38), NOP);
        br_taken = 1'b0; br_addr = '0; imem.imem_rdata = 32'hFACE;
        step();
        check("wrap", 1'b1, '0, 1'b1, MAXA, 32'hFACE);

        // Reset pulsed while a request is outstanding.
        imem.imem_ack = 1'b0; reset = 1'b1;
        step();
        check("reset_mid", 1'b0, '0, 1'b0, '0, NOP);
        reset = 1'b0;

        model_reset();
        for (int n = 0; n < 3000; n++) begin
            stall    = ($urandom_range(0, 3) == 0);
            br_taken = ($urandom_range(0, 9) == 0);
            br_addr  = ($urandom_range(0, 3) == 0) ? (MAXA - AW'($urandom_range(0, 2))) : AW'($urandom);
            imem.imem_ack   = $urandom_range(0, 1) == 1;
            imem.imem_rdata = mem_word(m_next);
            reset    = ($urandom_range(0, 199) == 0);
            model_edge(reset, stall, br_taken, br_addr, imem.imem_ack && model_req(), imem.imem_rdata);
            step();
            check($sformatf("rand%0d", n), model_req(), m_next, m_en, m_pc, m_insn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
